// File: rtl/linescanner_line_buffer.sv
// Ping-pong line buffer: captures one sensor line per bank and replays each completed
// line as a valid/ready pixel stream with first/last markers.
module linescanner_line_buffer #(
   parameter int PIXEL_WIDTH = 8,
   parameter int ADDR_WIDTH  = 10,
   parameter int LINE_LENGTH = 1024
) (
   input  logic                   main_clock,
   input  logic                   n_reset,
   input  logic                   enable,
   input  logic                   lval,
   input  logic                   pixel_captured,
   input  logic [PIXEL_WIDTH-1:0] pixel_data,
   output logic [PIXEL_WIDTH-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_first,
   output logic                   out_last,
   output logic                   line_dropped,
   output logic                   line_truncated
);
   localparam logic [ADDR_WIDTH:0] LINE_MAX = (ADDR_WIDTH+1)'(LINE_LENGTH);
   localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_CLOSE, W_SKIP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

   wstate_t w_state;
   rstate_t r_state;

   logic                   lval_prev;
   logic                   lval_rise;
   logic                   lval_fall;
   logic                   wr_bank;
   logic                   rd_bank;
   logic [ADDR_WIDTH:0]    wr_count;
   logic [ADDR_WIDTH:0]    wr_ptr;
   logic [ADDR_WIDTH:0]    rd_addr;
   logic                   start_fill;
   logic                   fill_active;
   logic                   wr_en;
   logic                   close_set;
   logic                   rd_clear;
   logic                   bank_full [2];
   logic [ADDR_WIDTH:0]    bank_len  [2];
   logic [PIXEL_WIDTH-1:0] mem [2*(2**ADDR_WIDTH)];

   assign lval_rise   = lval && !lval_prev;
   assign lval_fall   = !lval && lval_prev;
   assign start_fill  = (w_state == W_IDLE) && lval_rise && enable && !bank_full[wr_bank];
   assign fill_active = (w_state == W_FILL) || start_fill;
   // A pixel strobed on the rising-edge cycle itself still lands at address 0.
   assign wr_ptr      = start_fill ? '0 : wr_count;
   assign wr_en       = fill_active && pixel_captured && (wr_ptr < LINE_MAX);
   assign close_set   = (w_state == W_CLOSE) && (wr_count != '0);
   assign rd_clear    = (r_state == R_STREAM) && out_ready && out_last;

   always_ff @(posedge main_clock) begin
      if (wr_en)
         mem[{wr_bank, wr_ptr[ADDR_WIDTH-1:0]}] <= pixel_data;
   end

   always_ff @(posedge main_clock or negedge n_reset) begin
      if (!n_reset) begin
         w_state        <= W_IDLE;
         lval_prev      <= 1'b0;
         wr_bank        <= 1'b0;
         wr_count       <= '0;
         line_dropped   <= 1'b0;
         line_truncated <= 1'b0;
      end else begin
         lval_prev <= lval;
         if (fill_active && pixel_captured && !wr_en)
            line_truncated <= 1'b1;
         case (w_state)
            W_IDLE: begin
               if (start_fill) begin
                  w_state  <= W_FILL;
                  wr_count <= wr_en ? ONE : '0;
               end else if (lval_rise && enable) begin
                  w_state      <= W_SKIP;
                  line_dropped <= 1'b1;
               end
            end
            W_FILL: begin
               if (wr_en)
                  wr_count <= wr_count + ONE;
               if (lval_fall)
                  w_state <= W_CLOSE;
            end
            W_CLOSE: begin
               if (close_set)
                  wr_bank <= ~wr_bank;
               w_state <= W_IDLE;
            end
            W_SKIP: begin
               if (lval_fall)
                  w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Full is only ever set by the writer and cleared by the reader; they never target the same bank.
   always_ff @(posedge main_clock or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 2; i++) begin
            bank_full[i] <= 1'b0;
            bank_len[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (close_set && (wr_bank == i[0])) begin
               bank_full[i] <= 1'b1;
               bank_len[i]  <= wr_count;
            end else if (rd_clear && (rd_bank == i[0])) begin
               bank_full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge main_clock or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= R_IDLE;
         rd_bank   <= 1'b0;
         rd_addr   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (bank_full[rd_bank])
                  r_state <= R_FETCH;
            end
            R_FETCH: begin
               out_data  <= mem[{rd_bank, {ADDR_WIDTH{1'b0}}}];
               out_valid <= 1'b1;
               out_first <= 1'b1;
               out_last  <= (bank_len[rd_bank] == ONE);
               rd_addr   <= ONE;
               r_state   <= R_STREAM;
            end
            R_STREAM: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_first <= 1'b0;
                     out_last  <= 1'b0;
                     rd_bank   <= ~rd_bank;
                     r_state   <= R_IDLE;
                  end else begin
                     // rd_addr always points at the word to present after the current handshake.
                     out_data  <= mem[{rd_bank, rd_addr[ADDR_WIDTH-1:0]}];
                     out_first <= 1'b0;
                     out_last  <= (rd_addr == bank_len[rd_bank] - ONE);
                     rd_addr   <= rd_addr + ONE;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_linescanner_line_buffer.sv
// Directed bench for linescanner_line_buffer with a 16-pixel line; accepted beats are
// collected on the falling edge and compared against hand-computed lines.
module tb_linescanner_line_buffer;
   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       enable = 1'b1;
   logic       lval = 1'b0;
   logic       pixel_captured = 1'b0;
   logic [7:0] pixel_data = 8'h00;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_first;
   logic       out_last;
   logic       line_dropped;
   logic       line_truncated;

   typedef struct packed {
      logic       first;
      logic       last;
      logic [7:0] data;
   } beat_t;

   beat_t beats[$];
   int    n_vec = 0;
   int    n_bad = 0;
   logic  stall_pending = 1'b0;
   logic [9:0] held;

   linescanner_line_buffer #(
      .PIXEL_WIDTH(8),
      .ADDR_WIDTH (4),
      .LINE_LENGTH(16)
   ) dut (
      .main_clock    (clk),
      .n_reset       (n_reset),
      .enable        (enable),
      .lval          (lval),
      .pixel_captured(pixel_captured),
      .pixel_data    (pixel_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_first     (out_first),
      .out_last      (out_last),
      .line_dropped  (line_dropped),
      .line_truncated(line_truncated)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Collect accepted beats; while stalled, the presented word must not move.
   always @(negedge clk) begin
      if (n_reset && out_valid) begin
         if (stall_pending)
            check("stall_hold", {22'b0, out_first, out_last, out_data}, {22'b0, held});
         if (out_ready) begin
            beats.push_back('{first: out_first, last: out_last, data: out_data});
            stall_pending = 1'b0;
         end else begin
            stall_pending = 1'b1;
            held = {out_first, out_last, out_data};
         end
      end else begin
         stall_pending = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      n_reset = 1'b0;
      lval = 1'b0;
      pixel_captured = 1'b0;
      tick(2);
      n_reset = 1'b1;
      beats.delete();
      tick(1);
   endtask

   task automatic send_line(input int n, input int base);
      lval = 1'b1;
      pixel_captured = 1'b0;
      tick(1);
      for (int i = 0; i < n; i++) begin
         pixel_captured = 1'b1;
         pixel_data = 8'(base + i);
         tick(1);
      end
      pixel_captured = 1'b0;
      lval = 1'b0;
      tick(2);
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int k = 0; k < budget && beats.size() < n; k++)
         tick(1);
   endtask

   task automatic check_line(input string tag, input int n, input int base);
      for (int i = 0; i < n; i++) begin
         beat_t b;
         if (beats.size() == 0) begin
            check($sformatf("%s_missing%0d", tag, i), 32'd0, 32'd1);
            break;
         end
         b = beats.pop_front();
         check($sformatf("%s_beat%0d", tag, i),
               {22'b0, b.first, b.last, b.data},
               {22'b0, (i == 0), (i == n - 1), 8'(base + i)});
      end
   endtask

   initial begin
      // Reset state
      tick(2);
      check("rst_outputs", {21'b0, out_valid, out_first, out_last, out_data},
            32'd0);
      check("rst_flags", {30'b0, line_dropped, line_truncated}, 32'd0);
      n_reset = 1'b1;
      tick(1);

      // T1: one full-length line, consumer always ready
      out_ready = 1'b1;
      send_line(16, 0);
      wait_beats(16, 60);
      check("t1_count", beats.size(), 16);
      check_line("t1", 16, 0);
      check("t1_flags", {30'b0, line_dropped, line_truncated}, 32'd0);

      // T2: same line, consumer ready on alternate cycles
      out_ready = 1'b0;
      send_line(16, 0);
      for (int k = 0; k < 200 && beats.size() < 16; k++) begin
         out_ready = k[0];
         tick(1);
      end
      out_ready = 1'b1;
      tick(3);
      check("t2_count", beats.size(), 16);
      check_line("t2", 16, 0);

      // T3: three lines with consumer stalled -> third dropped
      apply_reset();
      out_ready = 1'b0;
      send_line(8, 8'h20);
      send_line(8, 8'h40);
      send_line(8, 8'h60);
      check("t3_dropped", {31'b0, line_dropped}, 32'd1);
      out_ready = 1'b1;
      wait_beats(16, 80);
      tick(30);
      check("t3_count", beats.size(), 16);
      check_line("t3_l1", 8, 8'h20);
      check_line("t3_l2", 8, 8'h40);

      // T4: over-long line truncated to LINE_LENGTH
      apply_reset();
      send_line(20, 0);
      wait_beats(16, 60);
      tick(5);
      check("t4_count", beats.size(), 16);
      check_line("t4", 16, 0);
      check("t4_flags", {30'b0, line_dropped, line_truncated}, 32'd1);

      // T5: empty line, then a line with enable low, then short lines
      apply_reset();
      lval = 1'b1;
      tick(3);
      lval = 1'b0;
      tick(10);
      check("t5_empty_line", beats.size(), 0);
      enable = 1'b0;
      send_line(4, 8'h50);
      enable = 1'b1;
      tick(15);
      check("t5_disabled_line", beats.size(), 0);
      check("t5_flags", {30'b0, line_dropped, line_truncated}, 32'd0);
      send_line(1, 8'h5a);
      wait_beats(1, 30);
      tick(3);
      check("t5_single_count", beats.size(), 1);
      check_line("t5_single", 1, 8'h5a);

      // T6: asynchronous reset mid-stream, then recovery
      send_line(16, 8'h80);
      for (int k = 0; k < 100 && beats.size() < 5; k++)
         @(negedge clk);
      check("t6_midstream", {31'b0, out_valid}, 32'd1);
      #1 n_reset = 1'b0;
      #1 check("t6_async_valid", {31'b0, out_valid}, 32'd0);
      tick(2);
      n_reset = 1'b1;
      beats.delete();
      tick(1);
      send_line(4, 8'h70);
      wait_beats(4, 40);
      tick(5);
      check("t6_count", beats.size(), 4);
      check_line("t6", 4, 8'h70);
      check("t6_flags", {30'b0, line_dropped, line_truncated}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end
endmodule
